// File: rtl/nnet_frame_sequencer_pkg.sv
// Shared types and helpers for the neural-net frame sequencer.
// Holds the sequencer state encoding, the default settings addresses and the statistics payload.
package nnet_seq_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned STAT_W = 32;

    localparam int unsigned SR_SIZE_INPUT_ADDR  = 129;
    localparam int unsigned SR_SIZE_OUTPUT_ADDR = 130;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        DISCARD,
        DRAIN
    } seq_state_e;

    typedef struct packed {
        logic [STAT_W-1:0] frames;
        logic [STAT_W-1:0] pads;
        logic [STAT_W-1:0] drops;
    } seq_stats_t;

    // Statistics stick at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/nnet_frame_sequencer_if.sv
// Stream and ap_fifo signal bundle around the frame sequencer.
// The slave modport is the sequencer's view; master is the view of the surrounding logic.
interface nnet_frame_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] i_tdata;
    logic             i_tlast;
    logic             i_tvalid;
    logic             i_tready;

    logic [WIDTH-1:0] core_din;
    logic             core_empty_n;
    logic             core_read;

    logic [WIDTH-1:0] core_dout;
    logic             core_full_n;
    logic             core_write;

    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;

    modport slave (
        input  i_tdata, i_tlast, i_tvalid,
        output i_tready,
        output core_din, core_empty_n,
        input  core_read,
        input  core_dout, core_write,
        output core_full_n,
        output o_tdata, o_tlast, o_tvalid,
        input  o_tready
    );

    modport master (
        output i_tdata, i_tlast, i_tvalid,
        input  i_tready,
        input  core_din, core_empty_n,
        output core_read,
        output core_dout, core_write,
        input  core_full_n,
        input  o_tdata, o_tlast, o_tvalid,
        output o_tready
    );

endinterface

// File: rtl/nnet_frame_sequencer_beat_counter.sv
// Beat counter with a limit captured on load; term_c flags the final beat (cnt == limit-1).
module nnet_beat_counter
    import nnet_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] limit,
    input  logic             en,
    output logic             term_c
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lim_q, lim_d;

    always_comb begin
        cnt_d = cnt_q;
        lim_d = lim_q;
        if (load) begin
            lim_d = limit;
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            lim_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lim_q <= lim_d;
        end
    end

    assign term_c = (cnt_q == (lim_q - CNT_W'(1)));

endmodule

// File: rtl/nnet_frame_sequencer_setting_reg.sv
// Settings-bus register: captures data_in when the strobe hits its address.
// Reset restores AT_RESET; only rst touches it so a soft clear keeps the value.
module setting_reg #(
    parameter logic [7:0]       MY_ADDR  = 8'd0,
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] AT_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic [7:0]       addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (strobe && (addr == MY_ADDR)) begin
            val_d = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= AT_RESET;
        end else begin
            val_q <= val_d;
        end
    end

    assign data_out = val_q;

endmodule

// File: rtl/nnet_frame_sequencer.sv
// Frame sequencer: reshapes each input packet into exactly size_in core reads and
// frames exactly size_out core writes with tlast, keeping frame/pad/drop statistics.
module nnet_frame_sequencer
    import nnet_seq_pkg::*;
#(
    parameter int unsigned WIDTH            = 16,
    parameter int unsigned SR_SIZE_INPUT    = SR_SIZE_INPUT_ADDR,
    parameter int unsigned SR_SIZE_OUTPUT   = SR_SIZE_OUTPUT_ADDR,
    parameter int unsigned DEFAULT_SIZE_IN  = 16,
    parameter int unsigned DEFAULT_SIZE_OUT = 8
) (
    input  logic                  ce_clk,
    input  logic                  ce_rst,
    input  logic                  clear,
    input  logic                  set_stb,
    input  logic [7:0]            set_addr,
    input  logic [31:0]           set_data,
    nnet_frame_sequencer_if.slave bus,
    output logic                  busy,
    output logic [STAT_W-1:0]     frame_count,
    output logic [STAT_W-1:0]     pad_count,
    output logic [STAT_W-1:0]     drop_count
);

    seq_state_e       state_q, state_d;
    logic             out_done_q, out_done_d;
    seq_stats_t       stats_q, stats_d;

    logic [CNT_W-1:0] size_in, size_out;
    logic             soft_rst;
    logic             start_c, in_fire_c, out_fire_c, out_live_c;
    logic             in_term_c, out_term_c;
    logic             i_tready_c, empty_n_c;
    logic [WIDTH-1:0] din_c;
    logic             unused_set_hi;

    assign soft_rst      = ce_rst | clear;
    assign unused_set_hi = ^set_data[31:16];

    setting_reg #(
        .MY_ADDR (8'(SR_SIZE_INPUT)),
        .WIDTH   (CNT_W),
        .AT_RESET(CNT_W'(DEFAULT_SIZE_IN))
    ) u_size_in (
        .clk     (ce_clk),
        .rst     (ce_rst),
        .strobe  (set_stb),
        .addr    (set_addr),
        .data_in (set_data[15:0]),
        .data_out(size_in)
    );

    setting_reg #(
        .MY_ADDR (8'(SR_SIZE_OUTPUT)),
        .WIDTH   (CNT_W),
        .AT_RESET(CNT_W'(DEFAULT_SIZE_OUT))
    ) u_size_out (
        .clk     (ce_clk),
        .rst     (ce_rst),
        .strobe  (set_stb),
        .addr    (set_addr),
        .data_in (set_data[15:0]),
        .data_out(size_out)
    );

    // Sizes are captured inside the counters on the IDLE->FILL edge only.
    assign start_c    = (state_q == IDLE) && (size_in != '0) && (size_out != '0);
    assign in_fire_c  = bus.core_read &&
                        (((state_q == FILL) && bus.i_tvalid) || (state_q == PAD));
    assign out_live_c = busy && !out_done_q;
    assign out_fire_c = bus.core_write && bus.core_full_n;

    nnet_beat_counter u_in_cnt (
        .clk   (ce_clk),
        .rst   (soft_rst),
        .load  (start_c),
        .limit (size_in),
        .en    (in_fire_c),
        .term_c(in_term_c)
    );

    nnet_beat_counter u_out_cnt (
        .clk   (ce_clk),
        .rst   (soft_rst),
        .load  (start_c),
        .limit (size_out),
        .en    (out_fire_c),
        .term_c(out_term_c)
    );

    // Input-side sequencing, frame completion and statistics.
    always_comb begin
        state_d    = state_q;
        out_done_d = out_done_q;
        stats_d    = stats_q;
        i_tready_c = 1'b0;
        empty_n_c  = 1'b0;
        din_c      = '0;

        if (out_fire_c && out_term_c) begin
            out_done_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d    = FILL;
                    out_done_d = 1'b0;
                end
            end
            FILL: begin
                din_c      = bus.i_tdata;
                empty_n_c  = bus.i_tvalid;
                i_tready_c = bus.core_read;
                if (in_fire_c) begin
                    if (in_term_c) begin
                        state_d = bus.i_tlast ? DRAIN : DISCARD;
                    end else if (bus.i_tlast) begin
                        state_d      = PAD;
                        stats_d.pads = sat_inc(stats_q.pads);
                    end
                end
            end
            PAD: begin
                empty_n_c = 1'b1;
                if (bus.core_read && in_term_c) begin
                    state_d = DRAIN;
                end
            end
            DISCARD: begin
                i_tready_c = 1'b1;
                if (bus.i_tvalid) begin
                    stats_d.drops = sat_inc(stats_q.drops);
                    if (bus.i_tlast) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_done_q) begin
                    state_d        = IDLE;
                    stats_d.frames = sat_inc(stats_q.frames);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ce_clk) begin
        if (soft_rst) begin
            state_q    <= IDLE;
            out_done_q <= 1'b0;
            stats_q    <= '0;
        end else begin
            state_q    <= state_d;
            out_done_q <= out_done_d;
            stats_q    <= stats_d;
        end
    end

    assign busy             = (state_q != IDLE);
    assign bus.i_tready     = i_tready_c;
    assign bus.core_empty_n = empty_n_c;
    assign bus.core_din     = din_c;

    // Writes past the frame's last result stall the core rather than leak downstream.
    assign bus.core_full_n  = bus.o_tready && out_live_c;
    assign bus.o_tdata      = bus.core_dout;
    assign bus.o_tvalid     = bus.core_write && out_live_c;
    assign bus.o_tlast      = bus.core_write && out_live_c && out_term_c;

    assign frame_count      = stats_q.frames;
    assign pad_count        = stats_q.pads;
    assign drop_count       = stats_q.drops;

endmodule
